// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_pkg
// Brief    : Shared types and helpers for the bit-serial adder/subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  // Sequencer states: accept operands, shift bits through the cell, report.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bit-counter width for a given operand width; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_if
// Brief    : Operand handshake and result bus of the bit-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  // Requester side: presents operands, observes status and result.
  modport master (
    output start_valid, a, b, sub,
    input  start_ready, busy, done, result, cout, ovf
  );

  // Adder side.
  modport slave (
    input  start_valid, a, b, sub,
    output start_ready, busy, done, result, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Brief    : One-bit full adder cell; all arithmetic of the serial adder.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder (
  input  wire logic a,
  input  wire logic b,
  input  wire logic cin,
  output logic      s,
  output logic      cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial two's-complement adder/subtractor, LSB first, one
//            bit per clock through a single full_adder cell.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned          c_cnt_w    = cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0]   c_cnt_pen  = c_cnt_w'(WIDTH - 2);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_run;
  logic               w_last;
  logic               w_start_ready;
  logic               w_busy;
  logic               w_done;

  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_res_sr;
  logic               r_carry;
  logic               r_c_msb;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;
  logic               r_ovf;

  logic               w_s;
  logic               w_cout;

  full_adder u_full_adder (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_start_ready = 1'b0;
    w_busy        = 1'b0;
    w_done        = 1'b0;
    w_accept      = 1'b0;
    w_run         = 1'b0;
    w_last        = 1'b0;
    case (r_state)
      IDLE: begin
        w_start_ready = 1'b1;
        if (bus.start_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        w_run  = 1'b1;
        if (r_cnt == c_cnt_last) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand/result shifting, carry chain and final result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_carry  <= 1'b0;
      r_c_msb  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
      r_a_sr  <= bus.a;
      r_b_sr  <= bus.b ^ {WIDTH{bus.sub}};
      r_carry <= bus.sub;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_res_sr <= {w_s, r_res_sr[WIDTH-1:1]};
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_carry  <= w_cout;
      r_cnt    <= r_cnt + 1'b1;
      // Carry out of bit WIDTH-2 is the carry into the MSB; holding it in
      // its own register lets the overflow flag form on the final edge.
      if (r_cnt == c_cnt_pen) begin
        r_c_msb <= w_cout;
      end
      if (w_last) begin
        r_result <= {w_s, r_res_sr[WIDTH-1:1]};
        r_cout   <= w_cout;
        r_ovf    <= r_c_msb ^ w_cout;
      end
    end
  end

  assign bus.start_ready = w_start_ready;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.result      = r_result;
  assign bus.cout        = r_cout;
  assign bus.ovf         = r_ovf;

endmodule
`default_nettype wire
